// File: rtl/l2_cache.sv
// Shared word store with two single-outstanding request ports, round-robin
// arbitration, one-cycle registered responses and LL/SC reservations.
module l2_cache #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [66:0] mem_req0,
    input  logic [66:0] mem_req1,
    output logic [33:0] mem_resp0,
    output logic [33:0] mem_resp1
);

    localparam int IW = $clog2(MEM_WORDS);

    logic [31:0]   r_mem [MEM_WORDS] = '{default: 32'h0};
    logic [1:0]    r_pend_v;
    logic [66:0]   r_pend_req0;
    logic [66:0]   r_pend_req1;
    logic          r_ptr;
    logic [1:0]    r_res_v;
    logic [IW-1:0] r_res_idx [2];
    logic [33:0]   r_resp0;
    logic [33:0]   r_resp1;

    logic [1:0]    w_cand;
    logic [66:0]   w_cand_req0;
    logic [66:0]   w_cand_req1;
    logic          w_gnt_v;
    logic          w_gnt;
    logic [1:0]    w_take;
    logic [66:0]   w_sel_req;
    logic [IW-1:0] w_idx;
    logic          w_wr;
    logic          w_at;
    logic [31:0]   w_wdata;
    logic          w_sc_ok;
    logic          w_mem_we;
    logic [31:0]   w_rdata;
    logic [33:0]   w_resp;
    logic [1:0]    w_res_v_nxt;
    logic [IW-1:0] w_res_idx_nxt [2];
    logic          w_unused;

    // A pending entry always outranks a new arrival; arrivals while busy are dropped.
    assign w_cand[0]   = r_pend_v[0] | (mem_req0[66] & ~r_resp0[33]);
    assign w_cand[1]   = r_pend_v[1] | (mem_req1[66] & ~r_resp1[33]);
    assign w_cand_req0 = r_pend_v[0] ? r_pend_req0 : mem_req0;
    assign w_cand_req1 = r_pend_v[1] ? r_pend_req1 : mem_req1;

    assign w_gnt_v   = ~rst_n & (w_cand[0] | w_cand[1]);
    assign w_gnt     = (w_cand[0] & w_cand[1]) ? r_ptr : w_cand[1];
    assign w_take[0] = w_gnt_v & ~w_gnt;
    assign w_take[1] = w_gnt_v & w_gnt;
    assign w_sel_req = w_gnt ? w_cand_req1 : w_cand_req0;

    assign w_idx   = w_sel_req[IW+34:35];
    assign w_wr    = w_sel_req[65];
    assign w_at    = w_sel_req[0];
    assign w_wdata = w_sel_req[32:1];
    assign w_unused = ^{w_sel_req[66], w_sel_req[64:IW+35], w_sel_req[34:33]};

    assign w_sc_ok  = r_res_v[w_gnt] & (r_res_idx[w_gnt] == w_idx);
    assign w_mem_we = w_gnt_v & w_wr & (~w_at | w_sc_ok);
    assign w_rdata  = (w_gnt_v & ~w_wr) ? r_mem[w_idx] : 32'h0;
    assign w_resp   = {w_gnt_v, w_rdata, w_gnt_v & w_wr & w_at & w_sc_ok};

    always_comb begin
        w_res_v_nxt      = r_res_v;
        w_res_idx_nxt[0] = r_res_idx[0];
        w_res_idx_nxt[1] = r_res_idx[1];
        if (w_gnt_v) begin
            if (!w_wr && w_at) begin
                w_res_v_nxt[w_gnt]   = 1'b1;
                w_res_idx_nxt[w_gnt] = w_idx;
            end else if (w_wr && !w_at) begin
                if (r_res_idx[~w_gnt] == w_idx)
                    w_res_v_nxt[~w_gnt] = 1'b0;
            end else if (w_wr && w_at) begin
                w_res_v_nxt[w_gnt] = 1'b0;
                if (w_sc_ok && (r_res_idx[~w_gnt] == w_idx))
                    w_res_v_nxt[~w_gnt] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_pend_v     <= 2'b00;
            r_pend_req0  <= '0;
            r_pend_req1  <= '0;
            r_ptr        <= 1'b0;
            r_res_v      <= 2'b00;
            r_res_idx[0] <= '0;
            r_res_idx[1] <= '0;
            r_resp0      <= '0;
            r_resp1      <= '0;
        end else begin
            r_pend_v[0]  <= w_cand[0] & ~w_take[0];
            r_pend_v[1]  <= w_cand[1] & ~w_take[1];
            r_pend_req0  <= w_cand_req0;
            r_pend_req1  <= w_cand_req1;
            if (w_gnt_v)
                r_ptr <= ~w_gnt;
            r_res_v      <= w_res_v_nxt;
            r_res_idx[0] <= w_res_idx_nxt[0];
            r_res_idx[1] <= w_res_idx_nxt[1];
            r_resp0      <= w_take[0] ? w_resp : 34'h0;
            r_resp1      <= w_take[1] ? w_resp : 34'h0;
        end
    end

    // The array is deliberately outside reset: contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_idx] <= w_wdata;
    end

    assign mem_resp0 = r_resp0;
    assign mem_resp1 = r_resp1;

endmodule

// File: tb/tb_l2_cache.sv
// Randomized and directed checks of l2_cache against a transaction-level
// reference model of the shared store, arbitration and reservations.
module tb_l2_cache;

    localparam int MEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [66:0] req0, req1;
    logic [33:0] mem_resp0, mem_resp1;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    logic [31:0] m_mem [MEM_WORDS];
    bit          m_pv [2];
    logic [66:0] m_preq [2];
    bit          m_busy [2];
    int          m_ptr;
    bit          m_rv [2];
    int          m_ridx [2];

    l2_cache #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req0(req0), .mem_req1(req1),
        .mem_resp0(mem_resp0), .mem_resp1(mem_resp1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_pv[p] = 0; m_busy[p] = 0; m_rv[p] = 0; m_ridx[p] = 0; m_preq[p] = '0;
        end
        m_ptr = 0;
    endtask

    // One clock of the reference behaviour; returns the responses visible after the edge.
    task automatic model_cycle(input logic [66:0] in0, input logic [66:0] in1,
                               output logic [33:0] e0, output logic [33:0] e1);
        logic [66:0] in [2];
        logic [66:0] creq [2];
        bit          cand [2];
        logic [33:0] r;
        int g, o, idx;
        bit ok;
        in[0] = in0; in[1] = in1;
        for (int p = 0; p < 2; p++) begin
            if (m_pv[p]) begin cand[p] = 1; creq[p] = m_preq[p]; end
            else if (in[p][66] && !m_busy[p]) begin cand[p] = 1; creq[p] = in[p]; end
            else begin cand[p] = 0; creq[p] = '0; end
        end
        if (cand[0] && cand[1]) g = m_ptr;
        else if (cand[0]) g = 0;
        else if (cand[1]) g = 1;
        else g = -1;
        r = '0;
        if (g >= 0) begin
            o   = 1 - g;
            idx = int'((creq[g][64:33] >> 2) & (MEM_WORDS - 1));
            if (!creq[g][65]) begin
                r = {1'b1, m_mem[idx], 1'b0};
                if (creq[g][0]) begin m_rv[g] = 1; m_ridx[g] = idx; end
            end else if (!creq[g][0]) begin
                m_mem[idx] = creq[g][32:1];
                if (m_rv[o] && m_ridx[o] == idx) m_rv[o] = 0;
                r = {1'b1, 32'h0, 1'b0};
            end else begin
                ok = m_rv[g] && m_ridx[g] == idx;
                m_rv[g] = 0;
                if (ok) begin
                    m_mem[idx] = creq[g][32:1];
                    if (m_rv[o] && m_ridx[o] == idx) m_rv[o] = 0;
                end
                r = {1'b1, 32'h0, ok};
            end
            m_ptr = o;
        end
        for (int p = 0; p < 2; p++) begin
            m_pv[p]   = cand[p] && (g != p);
            m_preq[p] = creq[p];
            m_busy[p] = (g == p);
        end
        e0 = (g == 0) ? r : 34'h0;
        e1 = (g == 1) ? r : 34'h0;
    endtask

    task automatic step();
        logic [33:0] e0, e1;
        model_cycle(req0, req1, e0, e1);
        @(posedge clk);
        #1;
        check("resp0", {30'h0, mem_resp0}, {30'h0, e0});
        check("resp1", {30'h0, mem_resp1}, {30'h0, e1});
        req0 = '0;
        req1 = '0;
    endtask

    task automatic set_req(input int p, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input bit at);
        if (p == 0) req0 = {1'b1, wr, addr, wd, at};
        else        req1 = {1'b1, wr, addr, wd, at};
    endtask

    task automatic txn(input string tag, input int p, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input bit at, input logic [31:0] rd, input bit sc);
        set_req(p, wr, addr, wd, at);
        step();
        check(tag, {30'h0, (p == 0) ? mem_resp0 : mem_resp1}, {30'h0, 1'b1, rd, sc});
        step();
    endtask

    // Asserted mid-cycle so the asynchronous clear is observable before any edge.
    task automatic rst_pulse();
        #2;
        rst_n = 1'b1;
        #1;
        check("rst_resp0", {30'h0, mem_resp0}, 64'h0);
        check("rst_resp1", {30'h0, mem_resp1}, 64'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        req0 = '0;
        req1 = '0;
        step();
    endtask

    initial begin
        logic [31:0] a;
        rst_n = 1'b1;
        req0 = '0;
        req1 = '0;
        for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = 32'h0;
        model_reset();
        #1;
        check("init_resp0", {30'h0, mem_resp0}, 64'h0);
        check("init_resp1", {30'h0, mem_resp1}, 64'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        step();

        // write on port 0 seen by a read on port 1
        txn("wr_10", 0, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0);
        txn("rd_10_p1", 1, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0);

        // collisions: pointer starts at port 0 after reset
        rst_pulse();
        set_req(0, 0, 32'h10, 32'h0, 0);
        set_req(1, 0, 32'h10, 32'h0, 0);
        step();
        check("coll1_first_p0", {30'h0, mem_resp0}, {30'h0, 1'b1, 32'hDEADBEEF, 1'b0});
        check("coll1_p1_waits", {63'h0, mem_resp1[33]}, 64'h0);
        step();
        check("coll1_second_p1", {30'h0, mem_resp1}, {30'h0, 1'b1, 32'hDEADBEEF, 1'b0});
        step();
        // a lone port-0 grant leaves the pointer on port 1 for the next collision
        txn("lone_p0", 0, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0);
        set_req(0, 0, 32'h10, 32'h0, 0);
        set_req(1, 0, 32'h10, 32'h0, 0);
        step();
        check("coll2_first_p1", {62'h0, mem_resp1[33], mem_resp0[33]}, 64'h2);
        step();
        check("coll2_second_p0", {63'h0, mem_resp0[33]}, 64'h1);
        step();

        // LL/SC success and failure
        txn("ll_20", 0, 0, 32'h20, 32'h0, 1, 32'h0, 0);
        txn("sc_20_ok", 0, 1, 32'h20, 32'h5, 1, 32'h0, 1);
        txn("rd_20_5", 1, 0, 32'h20, 32'h0, 0, 32'h5, 0);
        txn("ll_20b", 0, 0, 32'h20, 32'h0, 1, 32'h5, 0);
        txn("wr_20_p1", 1, 1, 32'h20, 32'h7, 0, 32'h0, 0);
        txn("sc_20_fail", 0, 1, 32'h20, 32'h9, 1, 32'h0, 0);
        txn("rd_20_7", 0, 0, 32'h20, 32'h0, 0, 32'h7, 0);
        txn("sc_no_resv", 1, 1, 32'h20, 32'h3, 1, 32'h0, 0);

        // competing SCs on one reservation index
        rst_pulse();
        txn("ll_40_p0", 0, 0, 32'h40, 32'h0, 1, 32'h0, 0);
        txn("ll_40_p1", 1, 0, 32'h40, 32'h0, 1, 32'h0, 0);
        set_req(0, 1, 32'h40, 32'hA, 1);
        set_req(1, 1, 32'h40, 32'hB, 1);
        step();
        check("sc40_p0_wins", {30'h0, mem_resp0}, {30'h0, 1'b1, 32'h0, 1'b1});
        step();
        check("sc40_p1_loses", {30'h0, mem_resp1}, {30'h0, 1'b1, 32'h0, 1'b0});
        step();
        txn("rd_40_A", 1, 0, 32'h40, 32'h0, 0, 32'hA, 0);

        // request while still being answered is dropped
        txn("wr_88", 0, 1, 32'h88, 32'h1, 0, 32'h0, 0);
        set_req(1, 1, 32'h8C, 32'h1, 0);
        step();
        set_req(1, 1, 32'h8C, 32'h2, 0);
        step();
        check("drop_no_resp", {63'h0, mem_resp1[33]}, 64'h0);
        step();
        txn("rd_8C_1", 0, 0, 32'h8C, 32'h0, 0, 32'h1, 0);

        // reset with a pending loser discards it
        rst_pulse();
        set_req(0, 1, 32'h80, 32'h1111, 0);
        set_req(1, 1, 32'h80, 32'h2222, 0);
        step();
        rst_pulse();
        repeat (2) step();
        txn("rd_80_after_rst", 1, 0, 32'h80, 32'h0, 0, 32'h1111, 0);
        // arrival held during reset is never accepted
        set_req(0, 1, 32'h84, 32'h55, 0);
        rst_pulse();
        txn("rd_84_untouched", 0, 0, 32'h84, 32'h0, 0, 32'h0, 0);

        // address aliasing modulo MEM_WORDS
        txn("wr_1004", 0, 1, 32'h1004, 32'hCAFE, 0, 32'h0, 0);
        txn("rd_4_alias", 1, 0, 32'h4, 32'h0, 0, 32'hCAFE, 0);

        // randomized traffic on a small, aliasing address set
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 99) < 45) begin
                    a = ($urandom_range(0, 3) << 2) | ($urandom_range(0, 1) << 12) | $urandom_range(0, 3);
                    set_req(p, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
